// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and default widths for ram_burst_ctrl.
// Holds the FSM state enum and the read-latency limit.
package ram_ctrl_pkg;

   localparam int AW_DEF     = 10;
   localparam int DW_DEF     = 8;
   localparam int LW_DEF     = 8;
   localparam int MAX_RD_LAT = 3;
   localparam int WAIT_W     = $clog2(MAX_RD_LAT + 1);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RD_ISSUE,
      RD_WAIT,
      RD_HOLD,
      DONE
   } state_e;

endpackage

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst read/write master for a single-port sync RAM.
// Optional macro RAM_ADDR_WRAP_EN: address wraps, no overrun rejection.
module ram_burst_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int LW     = LW_DEF,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [LW-1:0] cmd_len,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          busy,
   output logic          done,
   output logic          err
);

   state_e              state_q;
   logic [AW-1:0]       addr_q;
   logic [LW-1:0]       beats_q;
   logic [WAIT_W-1:0]   wait_q;
   logic                cmd_ready_q;
   logic                wr_ready_q;
   logic                rd_valid_q;
   logic [DW-1:0]       rd_data_q;
   logic                ram_we_q;
   logic [AW-1:0]       ram_addr_q;
   logic [DW-1:0]       ram_din_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;

   logic                reject_d;
   logic [AW-1:0]       addr_inc_d;
   logic [LW-1:0]       beats_dec_d;

   assign addr_inc_d  = addr_q + AW'(1);
   assign beats_dec_d = beats_q - LW'(1);

`ifdef RAM_ADDR_WRAP_EN
   // Counter wraps modulo 2^AW, so no burst is ever rejected.
   assign reject_d = 1'b0;
`else
   // Reject when the last beat would fall past the top of the RAM.
   logic [AW:0] end_addr_d;
   assign end_addr_d = {1'b0, cmd_addr} + (AW+1)'(cmd_len);
   assign reject_d   = end_addr_d[AW];
`endif

   // Burst FSM with every output held in a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         beats_q     <= '0;
         wait_q      <= '0;
         cmd_ready_q <= 1'b0;
         wr_ready_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         ram_we_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         unique case (state_q)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  addr_q      <= cmd_addr;
                  beats_q     <= cmd_len;
                  if (reject_d) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else if (cmd_write) begin
                     state_q    <= WRITE;
                     wr_ready_q <= 1'b1;
                  end else begin
                     state_q    <= RD_ISSUE;
                     ram_addr_q <= cmd_addr;
                  end
               end
            end
            WRITE: begin
               if (wr_valid && wr_ready_q) begin
                  ram_we_q   <= 1'b1;
                  ram_addr_q <= addr_q;
                  ram_din_q  <= wr_data;
                  addr_q     <= addr_inc_d;
                  beats_q    <= beats_dec_d;
                  if (beats_q == '0) begin
                     wr_ready_q <= 1'b0;
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                  end
               end
            end
            RD_ISSUE: begin
               state_q <= RD_WAIT;
               wait_q  <= WAIT_W'(RD_LAT - 1);
            end
            RD_WAIT: begin
               if (wait_q == '0) begin
                  rd_data_q  <= ram_dout;
                  rd_valid_q <= 1'b1;
                  state_q    <= RD_HOLD;
               end else begin
                  wait_q <= wait_q - WAIT_W'(1);
               end
            end
            RD_HOLD: begin
               if (rd_ready && rd_valid_q) begin
                  rd_valid_q <= 1'b0;
                  if (beats_q == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     addr_q     <= addr_inc_d;
                     beats_q    <= beats_dec_d;
                     ram_addr_q <= addr_inc_d;
                     state_q    <= RD_ISSUE;
                  end
               end
            end
            DONE: begin
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign wr_ready  = wr_ready_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: self-checking bench for ram_burst_ctrl with a
// behavioural 1K x 8 RAM and a reference memory image.
module tb_ram_burst_ctrl;

   localparam int DEPTH = 1024;

   typedef struct packed {
      logic [9:0] a;
      logic [7:0] d;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic [9:0] cmd_addr = '0;
   logic [7:0] cmd_len = '0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] wr_data = '0;
   logic       rd_valid;
   logic       rd_ready = 1'b0;
   logic [7:0] rd_data;
   logic       ram_we;
   logic [9:0] ram_addr;
   logic [7:0] ram_din;
   logic [7:0] ram_dout;
   logic       busy;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_burst_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout),
      .busy(busy), .done(done), .err(err)
   );

   // Synchronous single-port RAM, one cycle read latency
   logic       clr = 1'b1;
   logic [7:0] mem [DEPTH];
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
      end
      ram_dout <= mem[ram_addr];
   end

   // Monitor: log RAM write pulses and done/err pulses once per cycle
   wr_t wlog[$];
   int  done_cnt = 0;
   int  err_cnt = 0;
   always @(posedge clk) begin
      #1;
      if (rst_n === 1'b1) begin
         if (ram_we === 1'b1) wlog.push_back(wr_t'{a: ram_addr, d: ram_din});
         if (done === 1'b1) done_cnt++;
         if (err === 1'b1) err_cnt++;
      end
   end

   logic [32:0] outs;
   assign outs = {cmd_ready, wr_ready, rd_valid, rd_data, ram_we,
                  ram_addr, ram_din, busy, done, err};

   // Reference memory image, updated from burst semantics
   logic [7:0] ref_mem [DEPTH];

   function automatic logic [9:0] beat_addr(input int a, input int i);
      return 10'((a + i) % DEPTH);
   endfunction

   function automatic logic would_reject(input int a, input int len);
`ifdef RAM_ADDR_WRAP_EN
      return 1'b0;
`else
      return (a + len) > (DEPTH - 1);
`endif
   endfunction

   task automatic do_cmd(input logic w, input int a, input int len);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL cmd_ready_wait got=%b exp=1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = 10'(a);
      cmd_len   = 8'(len);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // gap: 0 = always valid, 1 = every other cycle, 2 = random
   task automatic do_write(input logic [7:0] data[$], input int gap);
      int   i = 0;
      int   cyc = 0;
      logic v;
      while (i < data.size() && cyc < 4000) begin
         if (gap == 1) v = (cyc % 2 == 0);
         else if (gap == 2) v = ($urandom_range(0, 2) != 0);
         else v = 1'b1;
         wr_valid = v;
         wr_data  = v ? data[i] : 8'($urandom);
         if (v && wr_ready === 1'b1) i++;
         @(negedge clk);
         cyc++;
      end
      wr_valid = 1'b0;
      checks++;
      if (i != data.size()) begin
         errors++;
         $display("FAIL wr_beats got=%0d exp=%0d", i, data.size());
      end
   endtask

   task automatic do_read(input int beats, input logic bp,
                          output logic [7:0] got[$]);
      int cyc = 0;
      got = {};
      while (got.size() < beats && cyc < 4000) begin
         rd_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (rd_ready && rd_valid === 1'b1) got.push_back(rd_data);
         @(negedge clk);
         cyc++;
      end
      rd_ready = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clr   = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outs got=%h exp=0", outs);
      end
      rst_n = 1'b1;
      clr   = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got=%b%b exp=10", cmd_ready, busy);
      end
   endtask

   task automatic test_write_single();
      int d0 = done_cnt;
      int e0 = err_cnt;
      logic [7:0] q[$];
      q = {8'h56};
      wlog.delete();
      do_cmd(1'b1, 55, 0);
      do_write(q, 0);
      wait_done(d0);
      ref_mem[55] = 8'h56;
      checks++;
      if (wlog.size() != 1) begin
         errors++;
         $display("FAIL wr1_count got=%0d exp=1", wlog.size());
      end else begin
         checks++;
         if (wlog[0] !== wr_t'{a: 10'd55, d: 8'h56}) begin
            errors++;
            $display("FAIL wr1_beat got=%h exp=%h", wlog[0],
                     wr_t'{a: 10'd55, d: 8'h56});
         end
      end
      checks++;
      if (done_cnt != d0 + 1 || err_cnt != e0) begin
         errors++;
         $display("FAIL wr1_done got=%0d/%0d exp=%0d/%0d",
                  done_cnt - d0, err_cnt - e0, 1, 0);
      end
   endtask

   task automatic test_write_gapped();
      int d0 = done_cnt;
      logic [7:0] q[$];
      q = {8'h36, 8'h37, 8'h38, 8'h39};
      wlog.delete();
      do_cmd(1'b1, 66, 3);
      do_write(q, 1);
      wait_done(d0);
      for (int i = 0; i < 4; i++) ref_mem[66 + i] = q[i];
      checks++;
      if (wlog.size() != 4) begin
         errors++;
         $display("FAIL wrgap_count got=%0d exp=4", wlog.size());
      end
      for (int i = 0; i < wlog.size() && i < 4; i++) begin
         checks++;
         if (wlog[i] !== wr_t'{a: beat_addr(66, i), d: q[i]}) begin
            errors++;
            $display("FAIL wrgap_beat%0d got=%h exp=%h", i, wlog[i],
                     wr_t'{a: beat_addr(66, i), d: q[i]});
         end
      end
   endtask

   task automatic test_read_burst();
      int d0 = done_cnt;
      logic [7:0] got[$];
      wlog.delete();
      do_cmd(1'b0, 66, 3);
      do_read(4, 1'b0, got);
      wait_done(d0);
      checks++;
      if (got.size() != 4 || wlog.size() != 0 || done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL rd4_count got=%0d/%0d/%0d exp=4/0/1",
                  got.size(), wlog.size(), done_cnt - d0);
      end
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i] !== ref_mem[beat_addr(66, i)]) begin
            errors++;
            $display("FAIL rd4_beat%0d got=%h exp=%h", i, got[i],
                     ref_mem[beat_addr(66, i)]);
         end
      end
   endtask

   task automatic test_read_hold();
      int d0 = done_cnt;
      int n = 0;
      rd_ready = 1'b0;
      do_cmd(1'b0, 55, 0);
      while (rd_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== ref_mem[55]) begin
            errors++;
            $display("FAIL hold_cyc%0d got=%b/%h exp=1/%h", k,
                     rd_valid, rd_data, ref_mem[55]);
         end
         @(negedge clk);
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_drop got=%b exp=0", rd_valid);
      end
      wait_done(d0);
      checks++;
      if (done_cnt != d0 + 1 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_done got=%0d/%b exp=1/0",
                  done_cnt - d0, rd_valid);
      end
   endtask

   task automatic test_boundary();
      int d0 = done_cnt;
      int e0 = err_cnt;
      logic [7:0] q[$];
      logic rej;
      int   nexp;
      q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
      rej = would_reject(1022, 3);
      wlog.delete();
      do_cmd(1'b1, 1022, 3);
      if (!rej) do_write(q, 0);
      wait_done(d0);
      nexp = rej ? 0 : 4;
      if (!rej) for (int i = 0; i < 4; i++) ref_mem[beat_addr(1022, i)] = q[i];
      checks++;
      if (done_cnt != d0 + 1 || err_cnt != e0 + int'(rej)) begin
         errors++;
         $display("FAIL bound_pulse got=%0d/%0d exp=1/%0d",
                  done_cnt - d0, err_cnt - e0, rej);
      end
      checks++;
      if (wlog.size() != nexp) begin
         errors++;
         $display("FAIL bound_count got=%0d exp=%0d", wlog.size(), nexp);
      end
      for (int i = 0; i < wlog.size() && i < nexp; i++) begin
         checks++;
         if (wlog[i] !== wr_t'{a: beat_addr(1022, i), d: q[i]}) begin
            errors++;
            $display("FAIL bound_beat%0d got=%h exp=%h", i, wlog[i],
                     wr_t'{a: beat_addr(1022, i), d: q[i]});
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] q[$];
      logic [7:0] got[$];
      logic [7:0] old2;
      int d0;
      for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
      old2 = ref_mem[302];
      wlog.delete();
      do_cmd(1'b1, 300, 7);
      do_write(q, 0);
      checks++;
      if (ram_we !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre got=%b exp=1", ram_we);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL rstmid_outs got=%h exp=0", outs);
      end
      ref_mem[300] = q[0];
      ref_mem[301] = q[1];
      repeat (2) @(negedge clk);
      checks++;
      if (mem[300] !== q[0] || mem[301] !== q[1] || mem[302] !== old2) begin
         errors++;
         $display("FAIL rstmid_ram got=%h%h%h exp=%h%h%h",
                  mem[300], mem[301], mem[302], q[0], q[1], old2);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_idle got=%b%b exp=10", cmd_ready, busy);
      end
      d0 = done_cnt;
      do_cmd(1'b0, 300, 2);
      do_read(3, 1'b0, got);
      wait_done(d0);
      checks++;
      if (got.size() != 3) begin
         errors++;
         $display("FAIL rstmid_rdcount got=%0d exp=3", got.size());
      end
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i] !== ref_mem[300 + i]) begin
            errors++;
            $display("FAIL rstmid_rd%0d got=%h exp=%h", i, got[i],
                     ref_mem[300 + i]);
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 14; it++) begin
         logic       w;
         logic       rej;
         int         a;
         int         len;
         int         d0;
         int         e0;
         logic [7:0] q[$];
         logic [7:0] got[$];
         w   = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255)
                                           : $urandom_range(0, 15);
         a   = ($urandom_range(0, 3) == 0) ? 1023 - $urandom_range(0, 20)
                                           : $urandom_range(0, 1023);
         rej = would_reject(a, len);
         d0  = done_cnt;
         e0  = err_cnt;
         q   = {};
         got = {};
         wlog.delete();
         do_cmd(w, a, len);
         if (!rej && w) begin
            for (int i = 0; i <= len; i++) q.push_back(8'($urandom));
            do_write(q, 2);
         end else if (!rej) begin
            do_read(len + 1, 1'b1, got);
         end
         wait_done(d0);
         checks++;
         if (done_cnt != d0 + 1 || err_cnt != e0 + int'(rej)) begin
            errors++;
            $display("FAIL rnd%0d_pulse got=%0d/%0d exp=1/%0d", it,
                     done_cnt - d0, err_cnt - e0, rej);
         end
         checks++;
         if (wlog.size() != q.size() || got.size() != ((!rej && !w) ? len + 1 : 0))
         begin
            errors++;
            $display("FAIL rnd%0d_count got=%0d/%0d exp=%0d/%0d", it,
                     wlog.size(), got.size(), q.size(),
                     (!rej && !w) ? len + 1 : 0);
         end
         for (int i = 0; i < wlog.size() && i < q.size(); i++) begin
            checks++;
            if (wlog[i] !== wr_t'{a: beat_addr(a, i), d: q[i]}) begin
               errors++;
               $display("FAIL rnd%0d_wr%0d got=%h exp=%h", it, i, wlog[i],
                        wr_t'{a: beat_addr(a, i), d: q[i]});
            end
         end
         for (int i = 0; i < q.size(); i++) ref_mem[beat_addr(a, i)] = q[i];
         for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== ref_mem[beat_addr(a, i)]) begin
               errors++;
               $display("FAIL rnd%0d_rd%0d got=%h exp=%h", it, i, got[i],
                        ref_mem[beat_addr(a, i)]);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      test_reset();
      test_write_single();
      test_write_gapped();
      test_read_burst();
      test_read_hold();
      test_boundary();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Burst access controller sitting directly upstream of the single-port 1K x 8 RAM (clk, write_enable, 10-bit address, 8-bit data_in/data_out). It accepts burst commands (start address, length, read or write) over a valid/ready handshake. Write bursts stream data into consecutive RAM locations; read bursts stream RAM contents out with backpressure. It is the only master driving the RAM port.

Parameters:
AW, 10, RAM address width
DW, 8, RAM data width
LW, 8, burst length field width (cmd_len = beats - 1)
RD_LAT, 1, clock cycles from registered ram_addr to valid ram_dout (1..3)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  AW  burst start address
cmd_len  in  LW  beats minus one
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat accepted when both high
wr_data  in  DW  write beat data
rd_valid  out  1  read beat available
rd_ready  in  1  read beat consumed when both high
rd_data  out  DW  read beat data
ram_we  out  1  to RAM write_enable
ram_addr  out  AW  to RAM address
ram_din  out  DW  to RAM data_in
ram_dout  in  DW  from RAM data_out
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at burst completion
err  out  1  one-cycle pulse with done on a rejected burst

Behaviour:
- One clock; reset is asynchronous and active-low. All outputs are registered. While rst_n is low, every output is 0 and the state is IDLE.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD, DONE.
- IDLE: cmd_ready=1. On a cmd handshake, latch addr into the address counter and cmd_len into the beat counter.
  - Boundary check, without the macro: if cmd_addr + cmd_len > 2^AW-1, go to DONE with err set; no RAM access occurs.
  - Otherwise go to WRITE (cmd_write=1) or RD_ISSUE (cmd_write=0).
- WRITE: wr_ready=1.
  - Each wr handshake: next cycle ram_we=1, ram_addr=counter, ram_din=wr_data. The RAM write lands one cycle after the handshake.
  - Counter increments per beat; beat counter decrements per beat.
  - ram_we is 0 in every cycle without a handshake.
  - After the last beat, go to DONE.
- RD_ISSUE: drive ram_addr=counter for one cycle, then RD_WAIT.
- RD_WAIT: wait RD_LAT cycles, capture ram_dout into rd_data, set rd_valid=1, go to RD_HOLD.
- RD_HOLD: hold rd_valid and rd_data stable until rd_ready.
  - On the handshake: rd_valid=0 next cycle.
  - If beats remain, go to RD_ISSUE; otherwise go to DONE.
  - Read throughput is one beat per RD_LAT+2 cycles at best.
- DONE: done=1 (and err if rejected) for exactly one cycle, then IDLE.
- cmd_ready=0 in every non-IDLE state. Commands are never queued.
- ram_we is never 1 outside WRITE or the cycle immediately following it.
- Reset mid-burst: ram_we drops immediately (async). The burst is abandoned and the RAM keeps the beats already written.
- Length 0 means one beat. Length 2^LW-1 means 2^LW beats.

Optional Feature:
RAM_ADDR_WRAP_EN
- Defined: the address counter wraps modulo 2^AW (1023 -> 0). The boundary check is removed and err is tied 0.
- Undefined: overrunning bursts are rejected as described in Behaviour.

Decomposition:
- Package ram_ctrl_pkg holds:
  - state enum type
  - default widths (AW=10, DW=8, LW=8)
  - max RD_LAT constant
- No sub-module needed. The address/beat counters and FSM stay in one module, about 200 lines.

Test Plan:
- Write addr 55, len 0, data 8'h56 -> one ram_we pulse, ram_addr=55, ram_din=8'h56, done pulse, err=0.
- Write addr 66, len 3, data 8'h36..8'h39, wr_valid gapped every other cycle -> exactly 4 ram_we pulses at 66..69 with matching data, ram_we=0 in gap cycles.
- Read addr 66, len 3, rd_ready=1 -> rd_data 8'h36, 8'h37, 8'h38, 8'h39 in order, then done.
- Read addr 55, len 0 with rd_ready held low 5 cycles -> rd_valid high and rd_data=8'h56 stable all 5 cycles, single beat delivered, then done.
- Write addr 1022, len 3:
  - without macro -> err+done pulse, no ram_we;
  - with RAM_ADDR_WRAP_EN -> writes at 1022, 1023, 0, 1.
- Assert rst_n low after beat 2 of a len-7 write -> ram_we=0 and all outputs 0 immediately, busy=0, cmd_ready=1 after release, RAM locations 0..1 of that burst hold the written data.
